writeback_unit: RTL and testbench

- Multi-cycle writeback stage that sits directly upstream of the register file in the non-pipelined microprogrammed core.
- The control sequencer starts it with a one-cycle `wb_start` pulse. It then selects the result source, waits for load data where needed, and aligns and extends that data.
- It drives the register-file write port (`reg_wrt_en` / `reg_wrt_addr` / `reg_wrt_data`) for exactly one cycle per committed instruction.

---
 rtl/writeback_unit_if.sv | 39 +++
 rtl/writeback_unit.sv | 140 ++++++++++++++
 tb/tb_writeback_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Writeback stage bus: sequencer start/operands, memory
// read return, and register-file write port.
interface writeback_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  wb_start;
  logic [1:0]            wb_src;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [2:0]            funct3;
  logic [1:0]            addr_lsb;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       imm;
  logic [XLEN-1:0]       mem_rdata;
  logic                  mem_rvalid;
  logic                  wb_busy;
  logic                  wb_done;
  logic                  wb_err;
  logic                  reg_wrt_en;
  logic [REG_ADDR_W-1:0] reg_wrt_addr;
  logic [XLEN-1:0]       reg_wrt_data;

  modport master (
    output wb_start, wb_src, rd_addr, funct3,
    output addr_lsb, alu_result, pc_plus4, imm,
    output mem_rdata, mem_rvalid,
    input  wb_busy, wb_done, wb_err,
    input  reg_wrt_en, reg_wrt_addr, reg_wrt_data
  );

  modport slave (
    input  wb_start, wb_src, rd_addr, funct3,
    input  addr_lsb, alu_result, pc_plus4, imm,
    input  mem_rdata, mem_rvalid,
    output wb_busy, wb_done, wb_err,
    output reg_wrt_en, reg_wrt_addr, reg_wrt_data
  );
endinterface

// File: rtl/writeback_unit.sv
// Multi-cycle writeback stage: source select, load wait,
// load align/extend, one-cycle register-file write.
module writeback_unit #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  writeback_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;
  logic [2:0]            r_f3;
  logic [1:0]            r_lsb;
  logic [7:0]            r_cnt;

  logic                  w_start;
  logic                  w_is_load;
  logic                  w_ld_bad;
  logic                  w_timeout;
  logic [XLEN-1:0]       w_src_val;
  logic [XLEN-1:0]       w_load_val;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_start   = (r_state == S_IDLE) && bus.wb_start;
  assign w_is_load = (bus.wb_src == 2'b01);
  assign w_timeout = (r_cnt == LP_LAST);

  // Reject unknown load types and misaligned halves/words
  always_comb begin
    w_ld_bad = 1'b1;
    unique case (bus.funct3)
      3'b000, 3'b100: w_ld_bad = 1'b0;
      3'b001, 3'b101: w_ld_bad = bus.addr_lsb[0];
      3'b010:         w_ld_bad = |bus.addr_lsb;
      default:        w_ld_bad = 1'b1;
    endcase
  end

  // Non-load result source select
  always_comb begin
    w_src_val = bus.alu_result;
    unique case (bus.wb_src)
      2'b10:   w_src_val = bus.pc_plus4;
      2'b11:   w_src_val = bus.imm;
      default: w_src_val = bus.alu_result;
    endcase
  end

  // Byte/half lane pick and sign/zero extension
  always_comb begin
    w_byte     = bus.mem_rdata[{r_lsb, 3'b000} +: 8];
    w_half     = bus.mem_rdata[{r_lsb[1], 4'b0000} +: 16];
    w_load_val = bus.mem_rdata;
    unique case (1'b1)
      (r_f3 == 3'b000):
        w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
      (r_f3 == 3'b100):
        w_load_val = {{(XLEN-8){1'b0}}, w_byte};
      (r_f3 == 3'b001):
        w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
      (r_f3 == 3'b101):
        w_load_val = {{(XLEN-16){1'b0}}, w_half};
      default:
        w_load_val = bus.mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state; memory data wins over timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.wb_start) begin
          if (!w_is_load)    w_next = S_WRITE;
          else if (w_ld_bad) w_next = S_ERR;
          else               w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid)  w_next = S_WRITE;
        else if (w_timeout)  w_next = S_ERR;
      end
      S_WRITE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latches, load data capture, wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd   <= '0;
      r_data <= '0;
      r_f3   <= '0;
      r_lsb  <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_rd  <= bus.rd_addr;
      r_f3  <= bus.funct3;
      r_lsb <= bus.addr_lsb;
      r_cnt <= '0;
      if (!w_is_load) r_data <= w_src_val;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
      if (bus.mem_rvalid) r_data <= w_load_val;
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    bus.wb_busy      = (r_state != S_IDLE);
    bus.wb_done      = (r_state == S_WRITE);
    bus.wb_err       = (r_state == S_ERR);
    bus.reg_wrt_en   = (r_state == S_WRITE) && (|r_rd);
    bus.reg_wrt_addr = r_rd;
    bus.reg_wrt_data = r_data;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus
// randomized transactions against a behavioural model.
module tb_writeback_unit;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  writeback_unit_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  writeback_unit #(
    .XLEN(32), .REG_ADDR_W(5), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          obs_done, obs_err, obs_en, obs_busy, obs_last;
  logic [31:0] obs_data;
  logic [4:0]  obs_addr;

  task automatic idle_inputs();
    bus.wb_start   = 1'b0;
    bus.wb_src     = 2'b00;
    bus.rd_addr    = '0;
    bus.funct3     = '0;
    bus.addr_lsb   = '0;
    bus.alu_result = '0;
    bus.pc_plus4   = '0;
    bus.imm        = '0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic scramble();
    bus.wb_src     = 2'($urandom);
    bus.rd_addr    = 5'($urandom);
    bus.funct3     = 3'($urandom);
    bus.addr_lsb   = 2'($urandom);
    bus.alu_result = $urandom;
    bus.pc_plus4   = $urandom;
    bus.imm        = $urandom;
  endtask

  // Expected outcome from the load/source rules
  function automatic void model(
    input  logic [1:0]  src,
    input  logic [2:0]  f3,
    input  logic [1:0]  lsb,
    input  logic [31:0] alu, pc, im, rdat,
    input  int          vat,
    output bit          err,
    output int          last,
    output logic [31:0] data
  );
    int unsigned b, h;
    bit ok;
    data = 0; err = 0; last = 1;
    if (src == 0)      data = alu;
    else if (src == 2) data = pc;
    else if (src == 3) data = im;
    else begin
      ok = (f3 == 0 || f3 == 4)
        || ((f3 == 1 || f3 == 5) && (lsb % 2 == 0))
        || (f3 == 2 && lsb == 0);
      b = (rdat >> (8 * lsb)) & 255;
      h = (rdat >> (16 * (lsb / 2))) & 65535;
      if (!ok) err = 1;
      else if (vat >= 1 && vat <= TO) begin
        last = vat + 1;
        case (f3)
          0: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          4: data = b;
          1: data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
          5: data = h;
          default: data = rdat;
        endcase
      end else begin
        err = 1; last = TO + 1;
      end
    end
  endfunction

  // Drive one transaction, record what the DUT does
  task automatic run_txn(
    input logic [1:0]  src,
    input logic [4:0]  rd,
    input logic [2:0]  f3,
    input logic [1:0]  lsb,
    input logic [31:0] alu, pc, im, rdat,
    input int          vat,
    input int          restart_at
  );
    obs_done = 0; obs_err = 0; obs_en = 0;
    obs_busy = 0; obs_last = 0;
    obs_data = 'x; obs_addr = 'x;
    @(negedge clk);
    bus.wb_start   = 1'b1;
    bus.wb_src     = src;
    bus.rd_addr    = rd;
    bus.funct3     = f3;
    bus.addr_lsb   = lsb;
    bus.alu_result = alu;
    bus.pc_plus4   = pc;
    bus.imm        = im;
    bus.mem_rvalid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.wb_busy) obs_busy++;
      if (bus.reg_wrt_en) obs_en++;
      if (bus.wb_err) begin
        obs_err++; obs_last = k;
      end
      if (bus.wb_done) begin
        obs_done++; obs_last = k;
        obs_data = bus.reg_wrt_data;
        obs_addr = bus.reg_wrt_addr;
      end
      scramble();
      bus.wb_start   = (k == restart_at);
      bus.mem_rvalid = (k == vat);
      bus.mem_rdata  = (k == vat) ? rdat : $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.wb_busy, bus.wb_done, bus.wb_err,
         bus.reg_wrt_en} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
        {bus.wb_busy, bus.wb_done, bus.wb_err,
         bus.reg_wrt_en});
    end
    n_tests++;
    if (bus.reg_wrt_addr !== 5'd0 ||
        bus.reg_wrt_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port got %h/%h want 0/0",
        bus.reg_wrt_addr, bus.reg_wrt_data);
    end
  endtask

  task automatic test_alu();
    run_txn(2'b00, 5'd5, 3'd0, 2'd0, 32'h1234,
      32'h0, 32'h0, 32'h0, 0, 0);
    n_tests++;
    if (obs_done !== 1 || obs_last !== 1) begin
      n_fail++;
      $display("FAIL alu_done got %0d@%0d want 1@1",
        obs_done, obs_last);
    end
    n_tests++;
    if (obs_en !== 1 || obs_addr !== 5'd5 ||
        obs_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL alu_write got %0d %0d %h want 1 5 1234",
        obs_en, obs_addr, obs_data);
    end
    n_tests++;
    if (obs_busy !== 1) begin
      n_fail++;
      $display("FAIL alu_busy got %0d want 1", obs_busy);
    end
  endtask

  task automatic test_loads();
    logic [31:0] exp [3] = '{32'hFFFF_FF80,
      32'h0000_0080, 32'h0000_1280};
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
    for (int i = 0; i < 3; i++) begin
      run_txn(2'b01, 5'd7, f3s[i], 2'd2, $urandom,
        $urandom, $urandom, 32'h1280_5634, 3, 0);
      n_tests++;
      if (obs_done !== 1 || obs_last !== 4 ||
          obs_busy !== 4) begin
        n_fail++;
        $display("FAIL load%0d_timing got %0d@%0d b%0d want 1@4 b4",
          i, obs_done, obs_last, obs_busy);
      end
      n_tests++;
      if (obs_data !== exp[i] || obs_addr !== 5'd7 ||
          obs_en !== 1) begin
        n_fail++;
        $display("FAIL load%0d_data got %h/%0d want %h/7",
          i, obs_data, obs_addr, exp[i]);
      end
    end
  endtask

  task automatic test_err();
    logic [2:0] f3s [2] = '{3'b010, 3'b011};
    for (int i = 0; i < 2; i++) begin
      run_txn(2'b01, 5'd9, f3s[i], 2'd1, $urandom,
        $urandom, $urandom, $urandom, 1, 0);
      n_tests++;
      if (obs_err !== 1 || obs_last !== 1 ||
          obs_busy !== 1) begin
        n_fail++;
        $display("FAIL err%0d got %0d@%0d b%0d want 1@1 b1",
          i, obs_err, obs_last, obs_busy);
      end
      n_tests++;
      if (obs_en !== 0 || obs_done !== 0) begin
        n_fail++;
        $display("FAIL err%0d_nowrite got en%0d d%0d want 0",
          i, obs_en, obs_done);
      end
    end
  endtask

  task automatic test_rd0();
    run_txn(2'b10, 5'd0, 3'd0, 2'd0, $urandom,
      32'h104, $urandom, 32'h0, 0, 0);
    n_tests++;
    if (obs_done !== 1 || obs_en !== 0 ||
        obs_data !== 32'h104) begin
      n_fail++;
      $display("FAIL rd0 got d%0d en%0d %h want d1 en0 104",
        obs_done, obs_en, obs_data);
    end
  endtask

  task automatic test_ignore_start();
    run_txn(2'b01, 5'd9, 3'b010, 2'd0, $urandom,
      $urandom, $urandom, 32'hCAFE_F00D, 3, 2);
    n_tests++;
    if (obs_done !== 1 || obs_en !== 1 ||
        obs_data !== 32'hCAFE_F00D || obs_addr !== 5'd9) begin
      n_fail++;
      $display("FAIL busy_start got d%0d en%0d %h/%0d want 1 1 cafef00d/9",
        obs_done, obs_en, obs_data, obs_addr);
    end
  endtask

  task automatic test_timeout();
    run_txn(2'b01, 5'd3, 3'b010, 2'd0, $urandom,
      $urandom, $urandom, $urandom, 0, 0);
    n_tests++;
    if (obs_err !== 1 || obs_last !== TO + 1 ||
        obs_done !== 0 || obs_en !== 0) begin
      n_fail++;
      $display("FAIL timeout got e%0d@%0d d%0d want e1@%0d d0",
        obs_err, obs_last, obs_done, TO + 1);
    end
    run_txn(2'b01, 5'd3, 3'b010, 2'd0, $urandom,
      $urandom, $urandom, 32'h0BAD_BEEF, TO, 0);
    n_tests++;
    if (obs_err !== 0 || obs_done !== 1 ||
        obs_last !== TO + 1 || obs_data !== 32'h0BAD_BEEF) begin
      n_fail++;
      $display("FAIL last_wait got e%0d d%0d@%0d %h want e0 d1@%0d 0badbeef",
        obs_err, obs_done, obs_last, obs_data, TO + 1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.wb_start = 1'b1; bus.wb_src = 2'b00;
    bus.rd_addr = 5'd3; bus.alu_result = 32'hA5A5_0001;
    @(negedge clk);
    n_tests++;
    if (bus.wb_done !== 1'b1 ||
        bus.reg_wrt_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL b2b_first got %b %h want 1 a5a50001",
        bus.wb_done, bus.reg_wrt_data);
    end
    bus.wb_start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.wb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got %b want 0", bus.wb_busy);
    end
    bus.wb_start = 1'b1; bus.wb_src = 2'b11;
    bus.rd_addr = 5'd4; bus.imm = 32'h5A5A_0002;
    @(negedge clk);
    bus.wb_start = 1'b0;
    n_tests++;
    if (bus.wb_done !== 1'b1 || bus.reg_wrt_en !== 1'b1 ||
        bus.reg_wrt_addr !== 5'd4 ||
        bus.reg_wrt_data !== 32'h5A5A_0002) begin
      n_fail++;
      $display("FAIL b2b_second got %b %b %0d %h want 1 1 4 5a5a0002",
        bus.wb_done, bus.reg_wrt_en, bus.reg_wrt_addr,
        bus.reg_wrt_data);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    int bad;
    @(negedge clk);
    bus.wb_start = 1'b1; bus.wb_src = 2'b01;
    bus.funct3 = 3'b010; bus.rd_addr = 5'd6;
    bus.addr_lsb = 2'd0;
    @(negedge clk);
    bus.wb_start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.wb_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre got %b want 1", bus.wb_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.wb_busy, bus.wb_done, bus.reg_wrt_en} !== 3'b0
        || bus.reg_wrt_data !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_now got %b %h want 000 0",
        {bus.wb_busy, bus.wb_done, bus.reg_wrt_en},
        bus.reg_wrt_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_rvalid = (k < 3);
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      if (bus.wb_busy || bus.wb_done || bus.reg_wrt_en)
        bad++;
    end
    idle_inputs();
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL arst_after got %0d active cycles want 0",
        bad);
    end
  endtask

  task automatic test_random();
    logic [1:0]  src, lsb;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, pc, im, rdat, ed;
    int          vat, el;
    bit          ee;
    for (int t = 0; t < 40; t++) begin
      src = 2'($urandom); lsb = 2'($urandom);
      f3 = 3'($urandom);  rd = 5'($urandom);
      if (t % 3 != 0) src = 2'b01;
      alu = $urandom; pc = $urandom;
      im = $urandom;  rdat = $urandom;
      vat = $urandom_range(0, TO + 2);
      model(src, f3, lsb, alu, pc, im, rdat, vat,
        ee, el, ed);
      run_txn(src, rd, f3, lsb, alu, pc, im, rdat, vat, 0);
      n_tests++;
      if (obs_err !== int'(ee) || obs_done !== int'(!ee) ||
          obs_last !== el || obs_busy !== el) begin
        n_fail++;
        $display("FAIL rnd%0d_flow got e%0d d%0d @%0d b%0d want e%0d @%0d",
          t, obs_err, obs_done, obs_last, obs_busy,
          ee, el);
      end
      n_tests++;
      if (obs_en !== int'(!ee && rd != 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_en got %0d want %0d",
          t, obs_en, int'(!ee && rd != 0));
      end
      if (!ee) begin
        n_tests++;
        if (obs_data !== ed || obs_addr !== rd) begin
          n_fail++;
          $display("FAIL rnd%0d_data got %h/%0d want %h/%0d",
            t, obs_data, obs_addr, ed, rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_err();
    test_rd0();
    test_ignore_start();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
      n_tests, n_fail);
    $finish;
  end

endmodule
